// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix coprocessor: instruction field
// positions, field widths, opcode encoding and default geometry.
package matriz_pkg;

    // Instruction word width
    localparam int INSTR_W = 32;

    // Field bit positions inside the instruction word (LSB-packed)
    localparam int RSV_HI_MSB = 31;
    localparam int RSV_HI_LSB = 30;
    localparam int OPC_MSB    = 29;
    localparam int OPC_LSB    = 26;
    localparam int LIN_MSB    = 25;
    localparam int LIN_LSB    = 23;
    localparam int COL_MSB    = 22;
    localparam int COL_LSB    = 20;
    localparam int DADO_MSB   = 19;
    localparam int DADO_LSB   = 4;
    localparam int ID_MSB     = 3;
    localparam int ID_LSB     = 2;
    localparam int RSV_LO_MSB = 1;
    localparam int RSV_LO_LSB = 0;

    // Field widths
    localparam int OPC_W  = OPC_MSB  - OPC_LSB  + 1;
    localparam int LIN_W  = LIN_MSB  - LIN_LSB  + 1;
    localparam int COL_W  = COL_MSB  - COL_LSB  + 1;
    localparam int DADO_W = DADO_MSB - DADO_LSB + 1;
    localparam int ID_W   = ID_MSB   - ID_LSB   + 1;

    // Default matrix geometry and highest legal opcode
    localparam int unsigned      MATRIX_DIM_DEF = 5;
    localparam logic [OPC_W-1:0] OPCODE_MAX_DEF = 4'd7;

    // Legal opcode encodings; anything above OP_7 is malformed
    typedef enum logic [OPC_W-1:0] {
        OP_0 = 4'd0,
        OP_1 = 4'd1,
        OP_2 = 4'd2,
        OP_3 = 4'd3,
        OP_4 = 4'd4,
        OP_5 = 4'd5,
        OP_6 = 4'd6,
        OP_7 = 4'd7
    } opcode_t;

    // Decoded field bundle carried through the output register
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [LIN_W-1:0]  linha;
        logic [COL_W-1:0]  coluna;
        logic [DADO_W-1:0] dado;
        logic [ID_W-1:0]   id_matriz;
    } campos_t;

endpackage

// File: rtl/instr_fields_split.sv
// Combinational slicing of an instruction word into its fields plus the
// malformed-instruction check. Fields are passed through verbatim even
// when the word is malformed; the consumer decides what to drop.
module instr_fields_split
    import matriz_pkg::*;
#(
    parameter int unsigned      MATRIX_DIM = MATRIX_DIM_DEF,
    parameter logic [OPC_W-1:0] OPCODE_MAX = OPCODE_MAX_DEF
) (
    input  logic [INSTR_W-1:0] instrucao_i,
    output logic [OPC_W-1:0]   opcode_o,
    output logic [LIN_W-1:0]   linha_o,
    output logic [COL_W-1:0]   coluna_o,
    output logic [DADO_W-1:0]  dado_o,
    output logic [ID_W-1:0]    id_matriz_o,
    output logic               erro_o
);

    logic opc_ruim;
    logic lin_ruim;
    logic col_ruim;
    logic rsv_ruim;

    assign opcode_o    = instrucao_i[OPC_MSB:OPC_LSB];
    assign linha_o     = instrucao_i[LIN_MSB:LIN_LSB];
    assign coluna_o    = instrucao_i[COL_MSB:COL_LSB];
    assign dado_o      = instrucao_i[DADO_MSB:DADO_LSB];
    assign id_matriz_o = instrucao_i[ID_MSB:ID_LSB];

    // Index checks are unsigned and zero-extended to the 32-bit geometry parameter
    assign opc_ruim = (opcode_o > OPCODE_MAX);
    assign lin_ruim = ({{(32-LIN_W){1'b0}}, linha_o}  >= MATRIX_DIM);
    assign col_ruim = ({{(32-COL_W){1'b0}}, coluna_o} >= MATRIX_DIM);
    assign rsv_ruim = (|instrucao_i[RSV_HI_MSB:RSV_HI_LSB]) |
                      (|instrucao_i[RSV_LO_MSB:RSV_LO_LSB]);

    assign erro_o = opc_ruim | lin_ruim | col_ruim | rsv_ruim;

endmodule

// File: rtl/decodificador_instrucao.sv
// Registered instruction decoder: one cycle from a valid instruction word
// to its decoded fields, error flag and a one-cycle out_valid pulse.
// Fields and erro hold their last decode while no instruction arrives.
module decodificador_instrucao
    import matriz_pkg::*;
#(
    parameter int unsigned      MATRIX_DIM = MATRIX_DIM_DEF,
    parameter logic [OPC_W-1:0] OPCODE_MAX = OPCODE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instrucao,
    output logic [OPC_W-1:0]   opcode,
    output logic [LIN_W-1:0]   linha,
    output logic [COL_W-1:0]   coluna,
    output logic [DADO_W-1:0]  dado,
    output logic [ID_W-1:0]    id_matriz,
    output logic               out_valid,
    output logic               erro
);

    campos_t split_campos;
    logic    split_erro;

    campos_t campos_d, campos_q;
    logic    erro_d, erro_q;
    logic    out_valid_d, out_valid_q;

    instr_fields_split #(
        .MATRIX_DIM (MATRIX_DIM),
        .OPCODE_MAX (OPCODE_MAX)
    ) u_split (
        .instrucao_i (instrucao),
        .opcode_o    (split_campos.opcode),
        .linha_o     (split_campos.linha),
        .coluna_o    (split_campos.coluna),
        .dado_o      (split_campos.dado),
        .id_matriz_o (split_campos.id_matriz),
        .erro_o      (split_erro)
    );

    // Next state: capture a new decode on instr_valid, otherwise hold
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no latch is inferred.
        campos_d    = campos_q;
        erro_d      = erro_q;
        out_valid_d = instr_valid;
        if (instr_valid) begin
            campos_d = split_campos;
            erro_d   = split_erro;
        end
    end

    // Output register with synchronous reset taking priority over a new decode
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (rst) begin
            campos_q    <= '0;
            erro_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            campos_q    <= campos_d;
            erro_q      <= erro_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign opcode    = campos_q.opcode;
    assign linha     = campos_q.linha;
    assign coluna    = campos_q.coluna;
    assign dado      = campos_q.dado;
    assign id_matriz = campos_q.id_matriz;
    assign erro      = erro_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_decodificador_instrucao.sv
// Self-checking bench for decodificador_instrucao. Expected decodes are
// pushed to a scoreboard as instructions are driven and popped when the
// DUT raises out_valid.
module tb_decodificador_instrucao;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instrucao;
    logic [3:0]  opcode;
    logic [2:0]  linha;
    logic [2:0]  coluna;
    logic [15:0] dado;
    logic [1:0]  id_matriz;
    logic        out_valid;
    logic        erro;

    // {opcode, linha, coluna, dado, id_matriz, erro}
    typedef logic [28:0] pack_t;

    pack_t sb[$];
    pack_t held;
    int    total = 0;
    int    bad   = 0;

    decodificador_instrucao dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instrucao   (instrucao),
        .opcode      (opcode),
        .linha       (linha),
        .coluna      (coluna),
        .dado        (dado),
        .id_matriz   (id_matriz),
        .out_valid   (out_valid),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    function automatic pack_t model(input logic [31:0] w);
        logic [3:0] o;
        logic [2:0] l;
        logic [2:0] c;
        logic       e;
        o = w[29:26];
        l = w[25:23];
        c = w[22:20];
        e = (o > 4'd7) || (l >= 3'd5) || (c >= 3'd5) ||
            (w[31:30] != 2'b00) || (w[1:0] != 2'b00);
        return {o, l, c, w[19:4], w[3:2], e};
    endfunction

    function automatic pack_t obs();
        return {opcode, linha, coluna, dado, id_matriz, erro};
    endfunction

    // Drive one cycle of stimulus, push the expected decode, sample after the edge
    task automatic drive(input logic r, input logic v, input logic [31:0] w, input pack_t e);
        rst         = r;
        instr_valid = v;
        instrucao   = w;
        if (v && !r) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'hFFFF_FFFF, '0);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_valid cyc=%0d got=%b want=0", i, out_valid);
            end
            total++;
            if (obs() !== pack_t'(0)) begin
                bad++;
                $display("FAIL reset_fields cyc=%0d got=%h want=0", i, obs());
            end
        end
        held = '0;
        sb.delete();
    endtask

    task automatic test_nominal();
        pack_t e;
        drive(1'b0, 1'b1, 32'h08C1_2344, {4'b0010, 3'b001, 3'b100, 16'h1234, 2'b01, 1'b0});
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL nominal_valid got=%b want=1", out_valid);
        end
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL nominal_fields got=%h want=%h", obs(), e);
        end
        held = e;
        drive(1'b0, 1'b0, 32'hDEAD_BEEF, '0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL nominal_pulse got=%b want=0", out_valid);
        end
        total++;
        if (obs() !== held) begin
            bad++;
            $display("FAIL nominal_hold got=%h want=%h", obs(), held);
        end
    endtask

    task automatic test_reserved();
        pack_t e;
        drive(1'b0, 1'b1, 32'hC8C1_2344, {4'b0010, 3'b001, 3'b100, 16'h1234, 2'b01, 1'b1});
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        total++;
        if (out_valid !== 1'b1 || obs() !== e) begin
            bad++;
            $display("FAIL reserved_hi got=%b/%h want=1/%h", out_valid, obs(), e);
        end
        drive(1'b0, 1'b1, 32'h08C1_2345, {4'b0010, 3'b001, 3'b100, 16'h1234, 2'b01, 1'b1});
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        total++;
        if (out_valid !== 1'b1 || obs() !== e) begin
            bad++;
            $display("FAIL reserved_lo got=%b/%h want=1/%h", out_valid, obs(), e);
        end
        held = e;
    endtask

    task automatic test_range();
        logic [31:0] words[4];
        pack_t       exps[4];
        pack_t       e;
        words[0] = 32'h0A81_2344;  // linha = 5
        exps[0]  = {4'b0010, 3'b101, 3'b000, 16'h1234, 2'b01, 1'b1};
        words[1] = 32'h20C1_2344;  // opcode = 8
        exps[1]  = {4'b1000, 3'b001, 3'b100, 16'h1234, 2'b01, 1'b1};
        words[2] = 32'h0A41_2344;  // linha = 4, coluna = 4: last legal indices
        exps[2]  = {4'b0010, 3'b100, 3'b100, 16'h1234, 2'b01, 1'b0};
        words[3] = 32'h1CD1_2348;  // opcode = 7, coluna = 5
        exps[3]  = {4'b0111, 3'b001, 3'b101, 16'h1234, 2'b10, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, words[i], exps[i]);
            e = (sb.size() != 0) ? sb.pop_front() : ~exps[i];
            total++;
            if (out_valid !== 1'b1 || obs() !== e) begin
                bad++;
                $display("FAIL range_%0d got=%b/%h want=1/%h", i, out_valid, obs(), e);
            end
            held = e;
        end
    endtask

    task automatic test_back_to_back();
        pack_t e;
        drive(1'b0, 1'b1, 32'h08C1_2344, {4'b0010, 3'b001, 3'b100, 16'h1234, 2'b01, 1'b0});
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        total++;
        if (out_valid !== 1'b1 || obs() !== e) begin
            bad++;
            $display("FAIL b2b_first got=%b/%h want=1/%h", out_valid, obs(), e);
        end
        drive(1'b0, 1'b1, 32'h0000_0000, '0);
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        total++;
        if (out_valid !== 1'b1 || obs() !== e) begin
            bad++;
            $display("FAIL b2b_second got=%b/%h want=1/%h", out_valid, obs(), e);
        end
        held = e;
        drive(1'b0, 1'b0, 32'h0000_0000, '0);
        total++;
        if (out_valid !== 1'b0 || obs() !== held) begin
            bad++;
            $display("FAIL b2b_idle got=%b/%h want=0/%h", out_valid, obs(), held);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b1, 32'h08C1_2344, model(32'h08C1_2344));
        void'(sb.pop_front());
        // Reset lands together with a new valid word: both decodes are discarded
        drive(1'b1, 1'b1, 32'h1CC1_2344, '0);
        total++;
        if (out_valid !== 1'b0 || obs() !== pack_t'(0)) begin
            bad++;
            $display("FAIL rst_priority got=%b/%h want=0/0", out_valid, obs());
        end
        held = '0;
        drive(1'b0, 1'b0, 32'h0000_0000, '0);
        total++;
        if (out_valid !== 1'b0 || obs() !== pack_t'(0)) begin
            bad++;
            $display("FAIL rst_after got=%b/%h want=0/0", out_valid, obs());
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        v;
        pack_t       e;
        for (int i = 0; i < 40; i++) begin
            w = $urandom();
            // Mostly clear the reserved bits so both legal and illegal words appear
            if ($urandom_range(3) != 0) begin
                w[31:30] = 2'b00;
                w[1:0]   = 2'b00;
            end
            v = ($urandom_range(3) != 0);
            drive(1'b0, v, w, model(w));
            if (v) begin
                e = (sb.size() != 0) ? sb.pop_front() : ~model(w);
                held = e;
            end
            total++;
            if (out_valid !== v || obs() !== held) begin
                bad++;
                $display("FAIL random_%0d w=%h got=%b/%h want=%b/%h",
                         i, w, out_valid, obs(), v, held);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b1;
        instrucao   = 32'hFFFF_FFFF;
        test_reset();
        test_nominal();
        test_reserved();
        test_range();
        test_back_to_back();
        test_reset_priority();
        test_random();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decodificador_instrucao.md
Name: decodificador_instrucao

Overview:
Registered instruction decoder for the matrix coprocessor. It splits a 32-bit instruction word into these fields: opcode, row (linha), column (coluna), 16-bit data (dado) and matrix id (id_matriz). It also flags malformed instructions. It sits between the instruction fetch/bus interface and the matrix control FSM, and has one cycle of latency.

Parameters:
- MATRIX_DIM, 5, number of rows/columns per matrix; linha and coluna must be < MATRIX_DIM.
- OPCODE_MAX, 4'd7, highest legal opcode; opcodes above it are illegal.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instrucao is valid this cycle.
- instrucao  input  32  raw instruction word.
- opcode  output  4  decoded opcode.
- linha  output  3  decoded row index.
- coluna  output  3  decoded column index.
- dado  output  16  decoded data/immediate.
- id_matriz  output  2  decoded matrix selector.
- out_valid  output  1  one-cycle pulse; the decoded fields and erro are fresh.
- erro  output  1  the decoded instruction is malformed (qualified by out_valid).

Behaviour:
- Bit layout (LSB-packed):
  - [31:30] reserved, must be 0.
  - [29:26] opcode.
  - [25:23] linha.
  - [22:20] coluna.
  - [19:4] dado.
  - [3:2] id_matriz.
  - [1:0] reserved, must be 0.
- Reset: on a rising clk edge with rst=1, all outputs go to 0 (opcode, linha, coluna, dado, id_matriz, out_valid, erro). rst has priority over instr_valid in the same cycle.
- Latency: instr_valid=1 sampled at edge N gives the decoded fields at edge N, and out_valid=1 for exactly the cycle following edge N.
- instr_valid=0: out_valid=0 next cycle. The field outputs and erro hold their last values.
- Back-to-back: instr_valid high on consecutive cycles gives one decode per cycle with out_valid continuously high. No stall or backpressure.
- erro is computed from the captured word and registered together with the fields. It is 1 if any of these holds:
  - opcode > OPCODE_MAX;
  - linha >= MATRIX_DIM;
  - coluna >= MATRIX_DIM;
  - any reserved bit ([31:30] or [1:0]) is nonzero.
- Fields are always decoded verbatim even when erro=1. The consumer drops the instruction.
- No arithmetic: pure bit slicing plus unsigned comparisons. Comparisons are zero-extended to the width of MATRIX_DIM/OPCODE_MAX.
- Reset asserted mid-stream: any pending decode is discarded. out_valid=0 in the cycle after the reset edge.

Decomposition:
- Shared package matriz_pkg holds:
  - field bit-position localparams: OPC_MSB/LSB, LIN_MSB/LSB, COL_MSB/LSB, DADO_MSB/LSB, ID_MSB/LSB;
  - field width constants;
  - the opcode enum/typedef (opcode_t, 4 bits);
  - the default MATRIX_DIM.
- Optional combinational sub-module instr_fields_split performs the slicing and error check. decodificador_instrucao wraps it with the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with instr_valid=1 and instrucao=32'hFFFFFFFF -> all outputs 0, out_valid=0.
- Nominal: instrucao=32'h08C12344, instr_valid=1 for one cycle -> next cycle opcode=4'b0010, linha=3'b001, coluna=3'b100, dado=16'h1234, id_matriz=2'b01, erro=0, out_valid=1. The following cycle out_valid=0 and the fields are held.
- Reserved bits: instrucao=32'hC8C12344 -> same field values as the nominal case, erro=1, out_valid=1.
- Range errors:
  - linha=3'b101 (instrucao=32'h0A812344) -> erro=1.
  - opcode=4'b1000 (instrucao=32'h20C12344) -> erro=1.
- Back-to-back: send 32'h08C12344 then 32'h00000000 on consecutive cycles -> out_valid high for two cycles; the second cycle shows all fields 0 and erro=0.
- Reset priority: rst=1 and instr_valid=1 in the same cycle -> out_valid=0, fields 0 next cycle.
